// File: rtl/store_queue_ctrl.sv
// -----------------------------------------------------------------------------
// store_queue_ctrl
//
// In-order store buffer between the core and the data memory write channel.
// Each store is checked for width/alignment, then formatted into byte lanes
// (word address, byte enables, positioned data) and pushed into a small FIFO.
// A two-state drain FSM presents the head entry on a req/gnt/ack channel and
// pops it when the write completes. A load-hazard flag reports whether any
// pending store, including the one in flight, targets the load's word.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   st_valid / st_ready      core store handshake (accept = valid && ready)
//   st_addr, st_data         byte address and raw register value of the store
//   st_funct3                000 SB, 001 SH, 010 SW; anything else is illegal
//   st_err                   one-cycle pulse after an illegal store is dropped
//   mem_req / mem_gnt        write request and its acceptance by memory
//   mem_ack                  write completion from memory
//   mem_addr, mem_wdata      word address and lane-positioned write data
//   mem_be                   byte enables, bit i = byte lane i
//   ld_addr / ld_hazard      execute-stage load address / pending-store overlap
//   empty                    nothing queued and nothing outstanding
// -----------------------------------------------------------------------------
module store_queue_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [DATA_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [2:0]        st_funct3,
    output logic              st_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] ld_addr,
    output logic              ld_hazard,
    output logic              empty
);

    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = DATA_W - 2;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        IDLE,
        WAIT_ACK
    } state_t;

    // Queue storage, one word address / byte-enable / data triple per slot.
    logic [WA_W-1:0]   q_waddr [DEPTH];
    logic [3:0]        q_be    [DEPTH];
    logic [DATA_W-1:0] q_wdata [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    state_t           state_q, state_d;
    logic             st_err_q;

    logic              accept, legal, push, pop, queue_empty;
    logic [1:0]        lane;
    logic [3:0]        fmt_be;
    logic [DATA_W-1:0] fmt_wdata;
    logic [PTR_W-1:0]  hz_off;

    assign queue_empty = (count_q == '0);
    assign st_ready    = (count_q != FULL_COUNT);
    assign accept      = st_valid && st_ready;
    assign push        = accept && legal;
    assign lane        = st_addr[1:0];

    // -------------------------------------------------------------------------
    // Legality check and lane formatting of the incoming store
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves a value unassigned and infers a latch.
        legal     = 1'b0;
        fmt_be    = 4'b0000;
        fmt_wdata = '0;
        case (st_funct3)
            3'b000: begin
                legal     = 1'b1;
                fmt_be    = 4'b0001 << lane;
                fmt_wdata = DATA_W'(st_data[7:0]) << {lane, 3'b000};
            end
            3'b001: begin
                legal     = !lane[0];
                fmt_be    = lane[1] ? 4'b1100 : 4'b0011;
                fmt_wdata = DATA_W'(st_data[15:0]) << {lane[1], 4'b0000};
            end
            3'b010: begin
                legal     = (lane == 2'b00);
                fmt_be    = 4'b1111;
                fmt_wdata = st_data;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Drain FSM: request the head in IDLE, wait for completion in WAIT_ACK.
    // A grant and ack in the same IDLE cycle completes the write at once.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                mem_req = !queue_empty;
                if (!queue_empty && mem_gnt) begin
                    if (mem_ack) pop = 1'b1;
                    else         state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (mem_ack) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The head stays on the bus through the whole handshake; the queue is
    // never empty in WAIT_ACK, so gating on occupancy alone zeroes idle outputs.
    assign mem_addr  = queue_empty ? '0 : {q_waddr[rd_ptr_q], 2'b00};
    assign mem_be    = queue_empty ? '0 : q_be[rd_ptr_q];
    assign mem_wdata = queue_empty ? '0 : q_wdata[rd_ptr_q];

    assign st_err = st_err_q;
    assign empty  = queue_empty && (state_q == IDLE);

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            st_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            st_err_q <= accept && !legal;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Entry storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; occupancy is tracked solely by
    // count_q, and every read of a slot is qualified by it.
    always_ff @(posedge clk) begin
        if (push) begin
            q_waddr[wr_ptr_q] <= st_addr[DATA_W-1:2];
            q_be[wr_ptr_q]    <= fmt_be;
            q_wdata[wr_ptr_q] <= fmt_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Load hazard: a slot is live when its distance from the head (mod DEPTH)
    // is below the occupancy. The store arriving this cycle is not compared.
    // -------------------------------------------------------------------------
    always_comb begin
        ld_hazard = 1'b0;
        hz_off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hz_off = PTR_W'(i) - rd_ptr_q;
            if ((CNT_W'(hz_off) < count_q) &&
                (q_waddr[i] == ld_addr[DATA_W-1:2])) begin
                ld_hazard = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_queue_ctrl.sv
module tb_store_queue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        st_err;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        empty;

    int passed = 0;
    int total  = 0;

    store_queue_ctrl #(.DATA_W(32), .DEPTH(4), .PTR_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_funct3 (st_funct3),
        .st_err    (st_err),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else passed++;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Present one store for a single cycle.
    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        st_valid  = 1'b1;
        st_addr   = a;
        st_data   = d;
        st_funct3 = f3;
        cyc();
        st_valid  = 1'b0;
        settle();
    endtask

    // Grant then acknowledge the head in two separate cycles.
    task automatic drain_one();
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        settle();
    endtask

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = 3'b010;
        mem_gnt = 1'b0; mem_ack = 1'b0; ld_addr = 32'h0000_0FFC;
        #12;
        // Reset state
        check("rst st_ready", st_ready, 1);
        check("rst st_err", st_err, 0);
        check("rst mem_req", mem_req, 0);
        check("rst mem_be", mem_be, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst ld_hazard", ld_hazard, 0);
        check("rst empty", empty, 1);
        rst_n = 1'b1;
        cyc();

        // SW 0x100: req at T+1, gnt at T+1, ack at T+3, empty at T+4
        push(32'h100, 32'hDEAD_BEEF, 3'b010);
        check("sw req T+1", mem_req, 1);
        check("sw addr", mem_addr, 32'h100);
        check("sw be", mem_be, 4'b1111);
        check("sw wdata", mem_wdata, 32'hDEAD_BEEF);
        check("sw empty busy", empty, 0);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        settle();
        check("wait req low", mem_req, 0);
        check("wait addr held", mem_addr, 32'h100);
        check("wait be held", mem_be, 4'b1111);
        cyc();
        check("wait2 req low", mem_req, 0);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        settle();
        check("sw empty T+4", empty, 1);
        check("sw idle be", mem_be, 0);

        // SB 0x203: lane 3
        push(32'h203, 32'h0000_00A5, 3'b000);
        check("sb addr", mem_addr, 32'h200);
        check("sb be", mem_be, 4'b1000);
        check("sb wdata", mem_wdata, 32'hA500_0000);
        // Grant and ack together in IDLE: immediate pop
        mem_gnt = 1'b1; mem_ack = 1'b1;
        cyc();
        mem_gnt = 1'b0; mem_ack = 1'b0;
        settle();
        check("sb gnt+ack empty", empty, 1);

        // SH 0x202: upper half
        push(32'h202, 32'hFFFF_1234, 3'b001);
        check("sh addr", mem_addr, 32'h200);
        check("sh be", mem_be, 4'b1100);
        check("sh wdata", mem_wdata, 32'h1234_0000);
        // ack without gnt in IDLE is ignored
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        settle();
        check("stray ack ignored", mem_req, 1);
        drain_one();
        check("sh drained", empty, 1);

        // Illegal stores: consumed, st_err one cycle later only, no request
        push(32'h301, 32'h1111, 3'b001);
        check("err sh misalign", st_err, 1);
        check("err sh no req", mem_req, 0);
        check("err sh empty", empty, 1);
        cyc();
        check("err pulse ends", st_err, 0);
        push(32'h302, 32'h2222, 3'b010);
        check("err sw misalign", st_err, 1);
        push(32'h100, 32'h3333, 3'b011);
        check("err funct3", st_err, 1);
        check("err no req", mem_req, 0);
        cyc();
        check("err end", st_err, 0);
        check("err empty", empty, 1);

        // Fill with gnt held low: five SW, fifth held while full
        for (int i = 0; i < 4; i++) begin
            check("fill ready", st_ready, 1);
            push(32'h500 + 32'(4 * i), 32'hA0 + 32'(i), 3'b010);
        end
        check("full ready low", st_ready, 0);
        st_valid = 1'b1; st_addr = 32'h510; st_data = 32'hA4; st_funct3 = 3'b010;
        cyc();
        check("held ready low", st_ready, 0);
        check("held head", mem_addr, 32'h500);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        mem_ack = 1'b1;
        settle();
        check("ack cycle ready low", st_ready, 0);
        cyc();
        mem_ack = 1'b0;
        settle();
        check("ready after pop", st_ready, 1);
        cyc();
        st_valid = 1'b0;
        settle();
        check("full again", st_ready, 0);
        for (int i = 1; i < 5; i++) begin
            check("drain req", mem_req, 1);
            check("drain order", mem_addr, 32'h500 + 32'(4 * i));
            check("drain data", mem_wdata, 32'hA0 + 32'(i));
            drain_one();
        end
        check("fill drained", empty, 1);

        // Load hazard
        push(32'h400, 32'h5555, 3'b010);
        ld_addr = 32'h402;
        settle();
        check("hz same word", ld_hazard, 1);
        ld_addr = 32'h404;
        settle();
        check("hz next word", ld_hazard, 0);
        ld_addr = 32'h402;
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        settle();
        check("hz in flight", ld_hazard, 1);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        settle();
        check("hz after ack", ld_hazard, 0);

        // Reset while WAIT_ACK with three entries
        push(32'h700, 32'h1, 3'b010);
        push(32'h704, 32'h2, 3'b010);
        push(32'h708, 32'h3, 3'b010);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        settle();
        check("pre-rst wait", mem_req, 0);
        check("pre-rst busy", empty, 0);
        rst_n = 1'b0;
        settle();
        check("mid rst req", mem_req, 0);
        check("mid rst empty", empty, 1);
        check("mid rst ready", st_ready, 1);
        check("mid rst be", mem_be, 0);
        cyc();
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        settle();
        check("late ack empty", empty, 1);
        check("late ack ready", st_ready, 1);
        check("late ack req", mem_req, 0);
        push(32'h600, 32'hCAFE_F00D, 3'b010);
        check("post rst addr", mem_addr, 32'h600);
        check("post rst wdata", mem_wdata, 32'hCAFE_F00D);
        drain_one();
        check("post rst drained", empty, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
